axi4lite_rd_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite read-channel arbiter that shares the single SRAM read port between the instruction fetch unit (master 0) and the load path of the LSU (master 1). It sits between the core's fetch/load interfaces and `axi4lite_sram`'s AR/R channels. It serialises requests with round-robin priority, keeps one transaction outstanding at a time, and routes the response back to the granted master. The write channels bypass this block.

---
 rtl/axi4lite_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_axi4lite_rd_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi4lite_rd_arbiter
//
// Two-master, one-slave AXI4-Lite read-channel arbiter. Master 0 (instruction
// fetch) and master 1 (LSU load path) share a single SRAM read port. Requests
// are serialised with round-robin priority and only one transaction is in
// flight at a time. The response is routed back to the master that was granted.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   m0_* (AR/R)       : IFU read channel   (arvalid/araddr/arready,
//                                           rvalid/rdata/rresp/rready)
//   m1_* (AR/R)       : LSU read channel   (same signals as m0_*)
//   s_*  (AR/R)       : SRAM read channel  (arvalid/araddr/arready,
//                                           rvalid/rdata/rresp/rready)
// ---------------------------------------------------------------------------
module axi4lite_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_arvalid,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    output logic                  m0_arready,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic                  m0_rready,

    input  logic                  m1_arvalid,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    output logic                  m1_arready,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    input  logic                  m1_rready,

    output logic                  s_arvalid,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    output logic                  s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    logic                  owner;
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  any_req;
    logic                  win;
    logic                  grant;
    logic                  in_wait;
    logic                  r_hs;

    // Round-robin: on a tie the master that was not served last wins.
    always_comb begin
        any_req = m0_arvalid | m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            win = ~last;
        end else begin
            win = m1_arvalid;
        end
    end

    // Every handshake output is gated by rst so nothing leaks while resetting.
    assign grant      = !rst && (state == IDLE) && any_req;
    assign in_wait    = !rst && (state == WAIT);

    assign m0_arready = grant && !win;
    assign m1_arready = grant && win;

    assign s_arvalid  = !rst && (state == REQ);
    // The SRAM samples the address when its delay expires, so the address is
    // held for the whole transaction rather than only during AR.
    assign s_araddr   = addr_q;

    // Response forwarding is purely combinational in both directions.
    assign m0_rvalid  = in_wait && !owner && s_rvalid;
    assign m1_rvalid  = in_wait &&  owner && s_rvalid;
    assign s_rready   = in_wait && (owner ? m1_rready : m0_rready);
    assign r_hs       = s_rvalid && s_rready;

    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m1_rresp   = s_rresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;   // m0 wins the first tie after reset
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= win;
                        addr_q <= win ? m1_araddr : m0_araddr;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (s_arready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_hs) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_rd_arbiter
//
// Randomised bench for axi4lite_rd_arbiter. Two random masters, a random-delay
// SRAM responder and a transaction-level reference model of the arbitration
// rules (who may be granted, which master owns the single in-flight read,
// which data that master must receive back).
// ---------------------------------------------------------------------------
module tb_axi4lite_rd_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_arvalid, m1_arvalid;
    logic [AW-1:0] m0_araddr, m1_araddr;
    logic          m0_arready, m1_arready;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    m0_rresp, m1_rresp;
    logic          m0_rready, m1_rready;
    logic          s_arvalid;
    logic [AW-1:0] s_araddr;
    logic          s_arready;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rready;

    always #5 clk = ~clk;

    axi4lite_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rready(m1_rready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rready(s_rready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // The SRAM returns a fixed function of the address it sampled.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // Master side
    logic          mv [2];
    logic [AW-1:0] ma [2];
    logic          rr [2];
    logic [AW-1:0] issued [2];
    int            done [2];
    int            order_err;

    // Reference model of the arbiter: phase 0 = free, 1 = request towards SRAM
    // pending, 2 = waiting for response.
    int            ph;
    logic          own;
    logic          lst;
    logic [AW-1:0] aq;

    // SRAM responder
    logic          srv, sbusy, stale;
    int            scnt;
    logic [DW-1:0] sdat;
    logic [1:0]    srsp;
    logic          sary;
    int            rst_left;

    // Events observed in the current cycle, consumed by the driver.
    logic          g [2];
    logic          arh, rh, was_rst;

    task automatic apply_inputs();
        m0_arvalid = mv[0]; m0_araddr = ma[0]; m0_rready = rr[0];
        m1_arvalid = mv[1]; m1_araddr = ma[1]; m1_rready = rr[1];
        s_arready  = sary;
        s_rvalid   = srv; s_rdata = sdat; s_rresp = srsp;
    endtask

    // Compare outputs against the model, then advance the model by one cycle.
    task automatic check_cycle();
        logic any_req, win, e_ar0, e_ar1, e_sarv, e_rv0, e_rv1, e_srr;
        g[0] = 1'b0; g[1] = 1'b0; arh = 1'b0; rh = 1'b0; was_rst = rst;
        chk("m0_rdata_pass", m0_rdata, sdat);
        chk("m1_rresp_pass", m1_rresp, srsp);
        if (rst) begin
            chk("rst_m0_arready", m0_arready, 0);
            chk("rst_m1_arready", m1_arready, 0);
            chk("rst_s_arvalid", s_arvalid, 0);
            chk("rst_s_rready", s_rready, 0);
            chk("rst_m0_rvalid", m0_rvalid, 0);
            chk("rst_m1_rvalid", m1_rvalid, 0);
            ph = 0; own = 1'b0; lst = 1'b1; aq = '0;
            return;
        end
        any_req = mv[0] | mv[1];
        win     = (mv[0] && mv[1]) ? ~lst : mv[1];
        e_ar0   = (ph == 0) && any_req && !win;
        e_ar1   = (ph == 0) && any_req && win;
        e_sarv  = (ph == 1);
        e_rv0   = (ph == 2) && !own && srv;
        e_rv1   = (ph == 2) && own && srv;
        e_srr   = (ph == 2) && rr[own];
        chk("m0_arready", m0_arready, e_ar0);
        chk("m1_arready", m1_arready, e_ar1);
        chk("s_arvalid", s_arvalid, e_sarv);
        chk("s_araddr", s_araddr, aq);
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        chk("s_rready", s_rready, e_srr);
        case (ph)
            0: if (any_req) begin
                g[win] = 1'b1;
                own = win;
                aq = ma[win];
                issued[win] = ma[win];
                if (done[0] + done[1] > 0 && mv[0] && mv[1] && win == lst) order_err++;
                ph = 1;
            end
            1: if (sary) begin
                arh = 1'b1;
                ph = 2;
            end
            default: if (srv && rr[own]) begin
                rh = 1'b1;
                if (own) begin
                    chk("m1_rdata", m1_rdata, mem_data(issued[1]));
                    chk("m1_rresp", m1_rresp, srsp);
                end else begin
                    chk("m0_rdata", m0_rdata, mem_data(issued[0]));
                    chk("m0_rresp", m0_rresp, srsp);
                end
                done[own]++;
                lst = own;
                ph = 0;
            end
        endcase
    endtask

    // Generate the next cycle's stimulus from the events just observed.
    task automatic drive_next();
        if (rst_left > 0) begin
            rst = 1'b1;
            rst_left--;
        end else if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            rst_left = $urandom_range(0, 1);
        end else begin
            rst = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (g[i]) mv[i] = 1'b0;
            if (!mv[i] && ($urandom_range(0, 1) == 1)) begin
                mv[i] = 1'b1;
                ma[i] = $urandom;
            end
            rr[i] = ($urandom_range(0, 3) != 0);
        end
        sary = ($urandom_range(0, 1) == 1);
        if (was_rst) begin
            // A response left over from before reset may linger one cycle.
            sbusy = 1'b0;
            scnt  = 0;
            srv   = ($urandom_range(0, 1) == 1);
            stale = srv;
        end else begin
            if (stale) begin
                srv = 1'b0;
                stale = 1'b0;
            end
            if (rh) srv = 1'b0;
            if (arh) begin
                sbusy = 1'b1;
                scnt  = $urandom_range(0, 5);
            end
            if (sbusy && !srv) begin
                if (scnt == 0) begin
                    srv   = 1'b1;
                    sbusy = 1'b0;
                    sdat  = mem_data(s_araddr);
                    srsp  = 2'($urandom_range(0, 3));
                end else begin
                    scnt--;
                end
            end
        end
        if (!srv) begin
            sdat = $urandom;
            srsp = 2'($urandom_range(0, 3));
        end
        apply_inputs();
    endtask

    initial begin
        rst = 1'b1; rst_left = 1;
        mv[0] = 1'b1; mv[1] = 1'b1;
        ma[0] = 32'h0000_1000; ma[1] = 32'h8000_0010;
        rr[0] = 1'b1; rr[1] = 1'b1;
        issued[0] = '0; issued[1] = '0;
        done[0] = 0; done[1] = 0; order_err = 0;
        ph = 0; own = 1'b0; lst = 1'b1; aq = '0;
        srv = 1'b0; sbusy = 1'b0; stale = 1'b0; scnt = 0;
        sdat = '0; srsp = '0; sary = 1'b1;
        g[0] = 1'b0; g[1] = 1'b0; arh = 1'b0; rh = 1'b0; was_rst = 1'b1;
        apply_inputs();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
            drive_next();
        end
        chk("m0_progress", (done[0] > 10), 1);
        chk("m1_progress", (done[1] > 10), 1);
        chk("tie_order", order_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
